// File: rtl/down_counter_borrow.sv
// Loadable, cascadable down-counter with a one-cycle borrow pulse (bout) at terminal count.
// Latency: inputs sampled at a rising edge appear on the registered outputs right after that edge.
// Optional macro DOWN_COUNTER_AUTO_RELOAD_EN: reload from reload_reg on terminal and keep running; otherwise one-shot to DONE.
module down_counter_borrow #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             cin,
  output logic [WIDTH-1:0] nums,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] nums_q, nums_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             bout_q, bout_d;

  // State, count, reload value and borrow registers; async active-low clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      nums_q   <= '0;
      reload_q <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nums_q   <= nums_d;
      reload_q <= reload_d;
      bout_q   <= bout_d;
    end
  end

  // Next-state and datapath: load beats stop beats start beats cin.
  always_comb begin
    state_d  = state_q;
    nums_d   = nums_q;
    reload_d = reload_q;
    bout_d   = 1'b0;
    if (load) begin
      nums_d   = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // A zero preset has nothing to count, so it completes without a borrow.
          if (start) begin
            state_d = (nums_q != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          // A cin arriving together with stop is dropped.
          if (stop) begin
            state_d = IDLE;
          end else if (cin) begin
            // Terminal is detected at 1 so the count never wraps below zero.
            if (nums_q == WIDTH'(1)) begin
              bout_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              nums_d = reload_q;
`else
              nums_d  = '0;
              state_d = DONE;
`endif
            end else begin
              nums_d = nums_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          // Parked at zero until the next load.
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign nums = nums_q;
  assign bout = bout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_borrow.sv
// Scoreboarded bench for down_counter_borrow: stimulus pushes expected outputs, a monitor pops and compares.
// Expected values come from a behavioural model of the count/run rules.
// Directed scenarios first, then randomized load/start/stop/cin traffic with occasional async resets.
module tb_down_counter_borrow;
  localparam int W = 4;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         cin;
  logic [W-1:0] nums;
  logic         bout;
  logic         busy;
  logic         done;

  down_counter_borrow #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .cin      (cin),
    .nums     (nums),
    .bout     (bout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] nums;
    logic         bout;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  // Behavioural model: remaining count, reload preset, and whether the counter
  // is idle (0), running (1) or finished (2).
  int m_cnt;
  int m_rel;
  int m_mode;
  bit m_bout;

  function automatic void model_reset();
    m_cnt  = 0;
    m_rel  = 0;
    m_mode = 0;
    m_bout = 1'b0;
  endfunction

  function automatic void model_step(input bit l, input int lv, input bit s, input bit p, input bit c);
    m_bout = 1'b0;
    if (l) begin
      m_cnt  = lv;
      m_rel  = lv;
      m_mode = 0;
    end else if (m_mode == 1 && p) begin
      m_mode = 0;
    end else if (m_mode == 0 && s) begin
      m_mode = (m_cnt == 0) ? 2 : 1;
    end else if (m_mode == 1 && c) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_bout = 1'b1;
        if (AUTO) begin
          m_cnt = m_rel;
        end else begin
          m_mode = 2;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.nums = W'(m_cnt);
    e.bout = m_bout;
    e.busy = (m_mode == 1);
    e.done = (m_mode == 2);
    return e;
  endfunction

  // One clock of stimulus: drive after the falling edge, queue the expectation
  // for the outputs that follow the next rising edge.
  task automatic step(input bit l, input int lv, input bit s, input bit p, input bit c);
    @(negedge clk);
    #1;
    load     = l;
    load_val = W'(lv);
    start    = s;
    stop     = p;
    cin      = c;
    model_step(l, lv, s, p, c);
    step_no++;
    exp_q.push_back(model_out());
  endtask

  task automatic check_reset_now(input string tag);
    checks++;
    if ({nums, bout, busy, done} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s: got nums=%0d bout=%0b busy=%0b done=%0b, want all zero",
               tag, nums, bout, busy, done);
    end
  endtask

  // Drop rstn between clock edges and confirm the outputs clear immediately.
  task automatic async_reset();
    @(negedge clk);
    #2;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    cin   = 1'b0;
    rstn  = 1'b0;
    #1;
    check_reset_now("async_reset");
    model_reset();
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: the outputs are always presented, so compare on every falling edge
  // for which the stimulus has queued an expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({nums, bout, busy, done} !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t: got nums=%0d bout=%0b busy=%0b done=%0b, want nums=%0d bout=%0b busy=%0b done=%0b",
                   $time, nums, bout, busy, done, e.nums, e.bout, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    rstn     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    stop     = 1'b0;
    cin      = 1'b0;
    model_reset();
    #12;
    check_reset_now("power_on_reset");
    @(negedge clk);
    #1;
    rstn = 1'b1;

    // Load 3, start, seven cin pulses (one-shot stops at DONE, auto-reload wraps).
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Zero preset: start goes straight to DONE with no borrow.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // Pause: stop with cin drops the cin, then resume.
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Load abort mid-run, then restart with cin held high.
    step(1, 15, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    step(1, 9, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1);

    // Start and stop together while idle: start wins, stop is RUN-only.
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // Async reset mid-run; afterwards cin and start alone do not count.
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit l;
      bit s;
      bit p;
      bit c;
      int lv;
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end
      l  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 15) == 0);
      c  = ($urandom_range(0, 1) == 1);
      lv = int'($urandom_range(0, (1 << W) - 1));
      step(l, lv, s, p, c);
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
